// File: rtl/ppu_bg_render.sv
// Background tile renderer: fetches nametable, attribute and pattern data per tile,
// shifts pixels out and writes palette colours to a video buffer. Option: PPU_BG_CLIP_EN.
module ppu_bg_render #(
   parameter int H_ACTIVE    = 256,
   parameter int V_ACTIVE    = 240,
   parameter int LINE_CYCLES = 340,
   parameter int VBUF_AW     = 17
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [5:0]         i_ppuctrl,
   input  logic [7:0]         i_ppumask,
   input  logic [7:0]         i_ppuscrollX,
   input  logic [7:0]         i_ppuscrollY,
   input  logic               i_vblank,
   output logic [11:0]        o_nt_addr,
   input  logic [7:0]         i_nt_rdata,
   output logic [11:0]        o_pt_addr,
   input  logic [15:0]        i_pt_rdata,
   output logic [4:0]         o_plt_addr,
   input  logic [7:0]         i_plt_rdata,
   output logic               o_vbuf_we,
   output logic [VBUF_AW-1:0] o_vbuf_addr,
   output logic [7:0]         o_vbuf_wdata,
   output logic               o_busy,
   output logic               o_frame_done
);

   localparam int XW = $clog2(LINE_CYCLES);
   localparam int YW = $clog2(V_ACTIVE);

   logic [1:0]         vb_sync;
   logic               vb_fall;
   logic [XW-1:0]      x;
   logic [YW-1:0]      y;
   logic [2:0]         fine_x, fine_y;
   logic [4:0]         cx, cy, lat_cx;
   logic [1:0]         nt;
   logic               lat_nt0, bgsel;
   logic [15:0]        sh_pl, sh_ph, sh_al, sh_ah;
   logic               in_fetch, in_pix, clip;
   logic [2:0]         attr_idx;
   logic [1:0]         attr_pair;
   logic [3:0]         pix_sel;
   logic [3:0]         pix;
   logic [XW-1:0]      pix_col;
   logic [VBUF_AW-1:0] pix_addr;
   logic [4:0]         plt_next;
   logic               p1_valid, p2_valid;
   logic [VBUF_AW-1:0] p1_addr, p2_addr;
   logic               unused_ok;

   assign vb_fall   = vb_sync[1] & ~vb_sync[0];
   assign in_fetch  = o_busy && (x < XW'(H_ACTIVE + 16));
   assign in_pix    = o_busy && (x >= XW'(16)) && (x < XW'(H_ACTIVE + 16));
   assign attr_idx  = {cy[1], cx[1], 1'b0};
   assign attr_pair = i_nt_rdata[attr_idx +: 2];
   assign pix_sel   = 4'd15 - {1'b0, fine_x};
   assign pix       = {sh_ah[pix_sel], sh_al[pix_sel], sh_ph[pix_sel], sh_pl[pix_sel]};
   assign pix_col   = x - XW'(16);
   assign pix_addr  = VBUF_AW'(y) * VBUF_AW'(H_ACTIVE) + VBUF_AW'(pix_col);

`ifdef PPU_BG_CLIP_EN
   assign clip      = !i_ppumask[1] && (pix_col < XW'(8));
   assign unused_ok = &{1'b0, i_ppuctrl[5], i_ppuctrl[3:2], i_ppumask[7:4], i_ppumask[2]};
`else
   assign clip      = 1'b0;
   assign unused_ok = &{1'b0, i_ppuctrl[5], i_ppuctrl[3:2], i_ppumask[7:4], i_ppumask[2:1]};
`endif

   // Transparent pattern pixels and a disabled background both map to the backdrop entry.
   assign plt_next = (pix[1:0] == 2'b00 || !i_ppumask[3] || clip) ? 5'd0 : {1'b0, pix};

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      o_nt_addr = '0;
      o_pt_addr = '0;
      if (in_fetch) begin
         if (x[2:0] == 3'd5) begin
            o_nt_addr = {nt, cy, cx};
         end else if (x[2:0] == 3'd6) begin
            o_nt_addr = {nt, 4'b1111, cy[4:2], cx[4:2]};
            o_pt_addr = {bgsel, i_nt_rdata, fine_y};
         end
      end
   end

   // NOTE: all state uses nonblocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vb_sync      <= '0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         x            <= '0;
         y            <= '0;
         fine_x       <= '0;
         fine_y       <= '0;
         cx           <= '0;
         cy           <= '0;
         lat_cx       <= '0;
         nt           <= '0;
         lat_nt0      <= 1'b0;
         bgsel        <= 1'b0;
         sh_pl        <= '0;
         sh_ph        <= '0;
         sh_al        <= '0;
         sh_ah        <= '0;
         o_plt_addr   <= '0;
         p1_valid     <= 1'b0;
         p2_valid     <= 1'b0;
         p1_addr      <= '0;
         p2_addr      <= '0;
         o_vbuf_we    <= 1'b0;
         o_vbuf_addr  <= '0;
         o_vbuf_wdata <= '0;
      end else begin
         vb_sync      <= {vb_sync[0], i_vblank};
         o_frame_done <= 1'b0;

         // Palette lookup and buffer write trail the pixel by one and three cycles.
         o_plt_addr   <= in_pix ? plt_next : 5'd0;
         p1_valid     <= in_pix;
         p1_addr      <= pix_addr;
         p2_valid     <= p1_valid;
         p2_addr      <= p1_addr;
         o_vbuf_we    <= p2_valid;
         o_vbuf_addr  <= p2_addr;
         o_vbuf_wdata <= i_plt_rdata & (i_ppumask[0] ? 8'h30 : 8'hFF);

         if (vb_fall) begin
            o_busy  <= 1'b1;
            x       <= '0;
            y       <= '0;
            fine_x  <= i_ppuscrollX[2:0];
            cx      <= i_ppuscrollX[7:3];
            lat_cx  <= i_ppuscrollX[7:3];
            fine_y  <= i_ppuscrollY[2:0];
            cy      <= i_ppuscrollY[7:3];
            nt      <= i_ppuctrl[1:0];
            lat_nt0 <= i_ppuctrl[0];
            bgsel   <= i_ppuctrl[4];
            sh_pl   <= '0;
            sh_ph   <= '0;
            sh_al   <= '0;
            sh_ah   <= '0;
         end else if (o_busy) begin
            if (in_fetch) begin
               if (x[2:0] == 3'd7) begin
                  sh_pl <= {sh_pl[14:7], i_pt_rdata[7:0]};
                  sh_ph <= {sh_ph[14:7], i_pt_rdata[15:8]};
                  sh_al <= {sh_al[14:7], {8{attr_pair[0]}}};
                  sh_ah <= {sh_ah[14:7], {8{attr_pair[1]}}};
                  cx    <= cx + 5'd1;
                  if (cx == 5'd31) nt[0] <= ~nt[0];
               end else begin
                  sh_pl <= {sh_pl[14:0], 1'b0};
                  sh_ph <= {sh_ph[14:0], 1'b0};
                  sh_al <= {sh_al[14:0], 1'b0};
                  sh_ah <= {sh_ah[14:0], 1'b0};
               end
            end

            if (x == XW'(LINE_CYCLES - 1)) begin
               x      <= '0;
               cx     <= lat_cx;
               nt[0]  <= lat_nt0;
               fine_y <= fine_y + 3'd1;
               // Row 29 is the last tile row of a nametable; 30/31 alias the attribute area.
               if (fine_y == 3'd7) begin
                  if (cy == 5'd29) begin
                     cy    <= 5'd0;
                     nt[1] <= ~nt[1];
                  end else begin
                     cy <= (cy == 5'd31) ? 5'd0 : cy + 5'd1;
                  end
               end
               if (y == YW'(V_ACTIVE - 1)) begin
                  y            <= '0;
                  o_busy       <= 1'b0;
                  o_frame_done <= 1'b1;
               end else begin
                  y <= y + YW'(1);
               end
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ppu_bg_render.sv
// Scoreboard bench for ppu_bg_render: directed frames with hand-derived pixel colours,
// plus address/timing probes at fixed cycles of a frame.
module tb_ppu_bg_render;

   localparam int H  = 64;
   localparam int V  = 16;
   localparam int L  = 100;
   localparam int AW = 17;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [5:0]    i_ppuctrl;
   logic [7:0]    i_ppumask, i_ppuscrollX, i_ppuscrollY;
   logic          i_vblank;
   logic [11:0]   o_nt_addr, o_pt_addr;
   logic [7:0]    i_nt_rdata = '0;
   logic [15:0]   i_pt_rdata = '0;
   logic [4:0]    o_plt_addr;
   logic [7:0]    i_plt_rdata = '0;
   logic          o_vbuf_we;
   logic [AW-1:0] o_vbuf_addr;
   logic [7:0]    o_vbuf_wdata;
   logic          o_busy, o_frame_done;

   always #5 i_clk = ~i_clk;

   ppu_bg_render #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_CYCLES(L), .VBUF_AW(AW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_ppuctrl(i_ppuctrl), .i_ppumask(i_ppumask),
      .i_ppuscrollX(i_ppuscrollX), .i_ppuscrollY(i_ppuscrollY), .i_vblank(i_vblank),
      .o_nt_addr(o_nt_addr), .i_nt_rdata(i_nt_rdata), .o_pt_addr(o_pt_addr),
      .i_pt_rdata(i_pt_rdata), .o_plt_addr(o_plt_addr), .i_plt_rdata(i_plt_rdata),
      .o_vbuf_we(o_vbuf_we), .o_vbuf_addr(o_vbuf_addr), .o_vbuf_wdata(o_vbuf_wdata),
      .o_busy(o_busy), .o_frame_done(o_frame_done)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t         exp_q[$];
   int          errors = 0, checks = 0;
   int          done_cnt = 0, wr_cnt = 0;
   int          frame_d0, frame_w0, cyc;
   logic [7:0]  nt_mem [0:4095];
   logic [15:0] pt_mem [0:4095];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Synchronous RAM responders: address seen at an edge, data one cycle later.
   always begin : mem_model
      logic [11:0] na, pa;
      logic [4:0]  la;
      @(posedge i_clk);
      na = o_nt_addr;
      pa = o_pt_addr;
      la = o_plt_addr;
      #1;
      i_nt_rdata  = nt_mem[na];
      i_pt_rdata  = pt_mem[pa];
      i_plt_rdata = 8'h20 | {3'b000, la};
   end

   initial begin : monitor
      wr_t e;
      forever begin
         @(posedge i_clk);
         #3;
         if (o_frame_done) done_cnt++;
         if (o_vbuf_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               check("write_when_none_expected", {31'd0, o_vbuf_we}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", o_vbuf_addr, e.addr);
               check("wr_data", o_vbuf_wdata, e.data);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run exceeded time limit, errors=%0d", errors);
      $fatal(1);
   end

   function automatic logic [4:0] exp_plt(input int t, input int c, input int y);
      case (t)
         0, 6, 7, 10: return 5'h02;
         1:           return (c % 8 == 0) ? 5'h01 : 5'h00;
         2:           return (((c / 16) % 2) == 1) ? 5'h05 : 5'h01;
         3:           return ((c % 8) == ((y + 3) % 8)) ? 5'h01 : 5'h00;
         4:           return 5'h0A;
         8:           return (y < 8) ? 5'h00 : 5'h02;
`ifdef PPU_BG_CLIP_EN
         9:           return (c < 8) ? 5'h00 : 5'h02;
`else
         9:           return 5'h02;
`endif
         default:     return 5'h00;
      endcase
   endfunction

   task automatic push_frame(input int t, input int lines, input bit gray);
      wr_t e;
      for (int y = 0; y < lines; y++) begin
         for (int c = 0; c < H; c++) begin
            e.addr = AW'(y * H + c);
            e.data = 8'h20 | {3'b000, exp_plt(t, c, y)};
            if (gray) e.data = e.data & 8'h30;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic setup(input logic [5:0] ctrl, input logic [7:0] mask, input logic [7:0] sx,
                        input logic [7:0] sy, input logic [7:0] tile, input logic [7:0] attr);
      i_ppuctrl    = ctrl;
      i_ppumask    = mask;
      i_ppuscrollX = sx;
      i_ppuscrollY = sy;
      for (int a = 0; a < 4096; a++) nt_mem[a] = ((a % 1024) >= 'h3C0) ? attr : tile;
   endtask

   task automatic start_frame();
      bit seen;
      frame_d0 = done_cnt;
      frame_w0 = wr_cnt;
      i_vblank = 1'b1;
      repeat (4) @(posedge i_clk);
      #3;
      i_vblank = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge i_clk);
         #3;
         if (o_busy) seen = 1'b1;
      end
      check("frame_start", {31'd0, seen}, 32'd1);
      cyc = 0;
   endtask

   task automatic goto(input int y, input int x);
      int target;
      target = y * L + x;
      while (cyc < target) begin
         @(posedge i_clk);
         #3;
         cyc++;
      end
   endtask

   task automatic probe_nt(input string name, input int y, input int x, input logic [11:0] exp);
      goto(y, x);
      check(name, o_nt_addr, exp);
   endtask

   task automatic finish_frame(input int nwr);
      bit ended;
      ended = 1'b0;
      for (int i = 0; i < V * L + 50 && !ended; i++) begin
         @(posedge i_clk);
         #3;
         if (!o_busy) ended = 1'b1;
      end
      check("frame_end", {31'd0, ended}, 32'd1);
      repeat (5) @(posedge i_clk);
      #3;
      check("frame_done_pulses", done_cnt - frame_d0, 32'd1);
      check("frame_writes", wr_cnt - frame_w0, nwr);
      check("queue_drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      int w_before;
      for (int a = 0; a < 4096; a++) pt_mem[a] = 16'h0000;
      for (int r = 0; r < 8; r++) begin
         pt_mem[{1'b0, 8'h01, 3'(r)}] = 16'hFF00;
         pt_mem[{1'b1, 8'h01, 3'(r)}] = 16'h00FF;
         pt_mem[{1'b0, 8'h02, 3'(r)}] = 16'h0010;
         pt_mem[{1'b0, 8'h03, 3'(r)}] = {8'h00, 8'h80 >> r};
      end
      i_rst = 1'b1;
      i_vblank = 1'b0;
      setup(6'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h00);
      repeat (3) @(posedge i_clk);
      #3;
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
      check("rst_vbuf_we", {31'd0, o_vbuf_we}, 32'd0);
      check("rst_vbuf_addr", o_vbuf_addr, 32'd0);
      check("rst_nt_addr", o_nt_addr, 32'd0);
      check("rst_pt_addr", o_pt_addr, 32'd0);
      check("rst_plt_addr", o_plt_addr, 32'd0);
      i_rst = 1'b0;
      repeat (3) @(posedge i_clk);
      #3;

      // Plain tile 1, pattern FF00, attribute 0: first write lands at x=19.
      push_frame(0, V, 1'b0);
      start_frame();
      probe_nt("a_nt_x5", 0, 5, 12'h000);
      probe_nt("a_at_x6", 0, 6, 12'h3C0);
      check("a_pt_x6", o_pt_addr, 32'h008);
      probe_nt("a_nt_x7", 0, 7, 12'h000);
      check("a_pt_x7", o_pt_addr, 32'h000);
      goto(0, 16);
      check("a_plt_x16", o_plt_addr, 32'h00);
      goto(0, 17);
      check("a_plt_x17", o_plt_addr, 32'h02);
      goto(0, 18);
      check("a_we_x18", {31'd0, o_vbuf_we}, 32'd0);
      goto(0, 19);
      check("a_we_x19", {31'd0, o_vbuf_we}, 32'd1);
      check("a_addr_x19", o_vbuf_addr, 32'd0);
      finish_frame(H * V);

      // Fine X = 3 on a tile whose only set pixel is 3.
      setup(6'h00, 8'h0A, 8'h03, 8'h00, 8'h02, 8'h00);
      push_frame(1, V, 1'b0);
      start_frame();
      finish_frame(H * V);

      // Upper pattern table, nametable 1, attribute quadrants E4.
      setup(6'h11, 8'h0A, 8'h00, 8'h00, 8'h01, 8'hE4);
      push_frame(2, V, 1'b0);
      start_frame();
      probe_nt("c_nt_x5", 0, 5, 12'h400);
      probe_nt("c_at_x6", 0, 6, 12'h7C0);
      check("c_pt_x6", o_pt_addr, 32'h808);
      finish_frame(H * V);

      // Diagonal tile with fine Y = 3 exercises row selection and the row carry.
      setup(6'h00, 8'h0A, 8'h00, 8'h03, 8'h03, 8'h00);
      push_frame(3, V, 1'b0);
      start_frame();
      goto(0, 6);
      check("d_pt_x6", o_pt_addr, 32'h01B);
      finish_frame(H * V);

      // Grayscale: palette 0A reads 2A, written as 20.
      setup(6'h00, 8'h0B, 8'h00, 8'h00, 8'h01, 8'hAA);
      push_frame(4, V, 1'b1);
      start_frame();
      goto(0, 17);
      check("e_plt_x17", o_plt_addr, 32'h0A);
      finish_frame(H * V);

      // Background disabled: backdrop everywhere, writes still happen.
      setup(6'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00);
      push_frame(5, V, 1'b0);
      start_frame();
      goto(0, 17);
      check("f_plt_x17", o_plt_addr, 32'h00);
      finish_frame(H * V);

      // Coarse X 31: the second fetch crosses into nametable 1, reloaded next line.
      setup(6'h00, 8'h0A, 8'hF8, 8'h00, 8'h01, 8'h00);
      push_frame(6, V, 1'b0);
      start_frame();
      probe_nt("g_nt_t0", 0, 5, 12'h01F);
      probe_nt("g_nt_t1", 0, 13, 12'h400);
      probe_nt("g_nt_l1", 1, 5, 12'h01F);
      goto(1, 6);
      check("g_pt_l1", o_pt_addr, 32'h009);
      finish_frame(H * V);

      // Coarse Y 29 wraps to row 0 of the vertically adjacent nametable.
      setup(6'h00, 8'h0A, 8'h00, 8'hE8, 8'h01, 8'h00);
      push_frame(7, V, 1'b0);
      start_frame();
      probe_nt("h_nt_l0", 0, 5, 12'h3A0);
      probe_nt("h_nt_l7", 7, 5, 12'h3A0);
      probe_nt("h_nt_l8", 8, 5, 12'h800);
      finish_frame(H * V);

      // Coarse Y 31 reads attribute bytes as tiles, then wraps without a toggle.
      setup(6'h00, 8'h0A, 8'h00, 8'hF8, 8'h01, 8'h00);
      push_frame(8, V, 1'b0);
      start_frame();
      probe_nt("i_nt_l0", 0, 5, 12'h3E0);
      probe_nt("i_nt_l8", 8, 5, 12'h000);
      finish_frame(H * V);

      // Left-8 show cleared: only affects the clipping build.
      setup(6'h00, 8'h08, 8'h00, 8'h00, 8'h01, 8'h00);
      push_frame(9, V, 1'b0);
      start_frame();
      finish_frame(H * V);

      // Reset at line 8 aborts the frame; nothing is written until a new frame.
      setup(6'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h00);
      push_frame(10, 8, 1'b0);
      start_frame();
      goto(8, 0);
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #3;
      check("k_rst_busy", {31'd0, o_busy}, 32'd0);
      check("k_rst_we", {31'd0, o_vbuf_we}, 32'd0);
      check("k_rst_nt", o_nt_addr, 32'd0);
      check("k_rst_plt", o_plt_addr, 32'd0);
      i_rst = 1'b0;
      w_before = wr_cnt;
      repeat (300) @(posedge i_clk);
      #3;
      check("k_no_write_idle", wr_cnt - w_before, 32'd0);
      check("k_partial_writes", wr_cnt - frame_w0, 8 * H);
      check("k_no_done", done_cnt - frame_d0, 32'd0);
      check("k_busy_idle", {31'd0, o_busy}, 32'd0);
      push_frame(10, V, 1'b0);
      start_frame();
      finish_frame(H * V);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
